// File: rtl/clock_divider_prog_if.sv
// Control and status bundle for the programmable clock divider.
// The master drives the divisor/control strobes and the slave returns the divided clock and status.
interface clock_divider_prog_if #(
  parameter int unsigned CNT_W = 25
);
  logic             en;
  logic             sync_clr;
  logic             load;
  logic [CNT_W-1:0] div_in;
  logic             clk_out;
  logic             tick;
  logic             tap;
  logic             pending;
  logic [CNT_W-1:0] div_cur;

  modport master (
    output en, sync_clr, load, div_in,
    input  clk_out, tick, tap, pending, div_cur
  );

  modport slave (
    input  en, sync_clr, load, div_in,
    output clk_out, tick, tap, pending, div_cur
  );
endinterface

// File: rtl/clock_divider_prog.sv
// Runtime-programmable clock divider: toggles clk_out every div_cur+1 enabled cycles.
// A divisor loaded mid-phase is deferred to the next terminal count so no runt phases appear.
module clock_divider_prog #(
  parameter int unsigned     CNT_W       = 25,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = '1,
  parameter int unsigned     TAP_BIT     = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  clock_divider_prog_if.slave  bus
);

  logic [CNT_W-1:0] count_q,    count_d;
  logic [CNT_W-1:0] div_cur_q,  div_cur_d;
  logic [CNT_W-1:0] div_pend_q, div_pend_d;
  logic             clk_out_q,  clk_out_d;
  logic             tick_q,     tick_d;
  logic             pending_q,  pending_d;
  logic             terminal_c;

  // >= rather than == so a divisor that shrank below the running count still terminates
  assign terminal_c = bus.en && (count_q >= div_cur_q);

  // Next-state: sync_clr outranks the enable/terminal logic
  always_comb begin
    count_d    = count_q;
    div_cur_d  = div_cur_q;
    div_pend_d = div_pend_q;
    clk_out_d  = clk_out_q;
    tick_d     = 1'b0;
    pending_d  = pending_q;

    if (bus.sync_clr) begin
      count_d   = '0;
      clk_out_d = 1'b0;
      pending_d = 1'b0;
      if (bus.load) begin
        div_cur_d = bus.div_in;
      end else if (pending_q) begin
        div_cur_d = div_pend_q;
      end
    end else if (!bus.en) begin
      // No running phase to protect, so a load takes effect at once
      if (bus.load) begin
        div_cur_d = bus.div_in;
        pending_d = 1'b0;
      end
    end else if (terminal_c) begin
      count_d   = '0;
      clk_out_d = ~clk_out_q;
      tick_d    = 1'b1;
      pending_d = 1'b0;
      if (bus.load) begin
        div_cur_d = bus.div_in;
      end else if (pending_q) begin
        div_cur_d = div_pend_q;
      end
    end else begin
      count_d = count_q + CNT_W'(1);
      if (bus.load) begin
        div_pend_d = bus.div_in;
        pending_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      div_cur_q  <= DEFAULT_DIV;
      div_pend_q <= '0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      count_q    <= count_d;
      div_cur_q  <= div_cur_d;
      div_pend_q <= div_pend_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
      pending_q  <= pending_d;
    end
  end

  assign bus.clk_out = clk_out_q;
  assign bus.tick    = tick_q;
  assign bus.tap     = count_q[TAP_BIT];
  assign bus.pending = pending_q;
  assign bus.div_cur = div_cur_q;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Directed bench for clock_divider_prog: a cycle-level reference model checked every cycle,
// plus hand-computed literal expectations at the interesting edges.
module tb_clock_divider_prog;

  localparam int unsigned      CNT_W       = 8;
  localparam int unsigned      TAP_BIT     = 2;
  localparam logic [CNT_W-1:0] DEFAULT_DIV = 8'd200;

  logic clk;
  logic rst;

  clock_divider_prog_if #(.CNT_W(CNT_W)) bus ();

  clock_divider_prog #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV),
    .TAP_BIT     (TAP_BIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  // Reference model state, in plain integers
  int m_cnt, m_div, m_pval;
  bit m_out, m_tick, m_pending;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: one update per rising edge from the sampled inputs
  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0; m_out = 0; m_tick = 0; m_pending = 0; m_pval = 0;
      m_div = int'(DEFAULT_DIV);
    end else if (bus.sync_clr) begin
      m_cnt = 0; m_out = 0; m_tick = 0;
      if (bus.load)      m_div = int'(bus.div_in);
      else if (m_pending) m_div = m_pval;
      m_pending = 0;
    end else if (!bus.en) begin
      m_tick = 0;
      if (bus.load) begin
        m_div = int'(bus.div_in);
        m_pending = 0;
      end
    end else if (m_cnt + 1 >= m_div + 1) begin
      // Half-period of m_div+1 enabled edges has elapsed
      m_cnt = 0; m_out = !m_out; m_tick = 1;
      if (bus.load)      m_div = int'(bus.div_in);
      else if (m_pending) m_div = m_pval;
      m_pending = 0;
    end else begin
      m_cnt = m_cnt + 1; m_tick = 0;
      if (bus.load) begin
        m_pval = int'(bus.div_in);
        m_pending = 1;
      end
    end
  end

  // Every-cycle comparison, away from the active edge
  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_clk_out", 32'(bus.clk_out), 32'(m_out));
      chk("m_tick",    32'(bus.tick),    32'(m_tick));
      chk("m_tap",     32'(bus.tap),     32'((m_cnt >> TAP_BIT) & 1));
      chk("m_pending", 32'(bus.pending), 32'(m_pending));
      chk("m_div_cur", 32'(bus.div_cur), 32'(m_div));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_load(input logic [CNT_W-1:0] d);
    bus.load = 1'b1; bus.div_in = d;
    step(1);
    bus.load = 1'b0;
  endtask

  // Stop counting, restart the phase with divisor d, then enable
  task automatic restart(input logic [CNT_W-1:0] d);
    bus.en = 1'b0; bus.sync_clr = 1'b1; bus.load = 1'b1; bus.div_in = d;
    step(1);
    bus.sync_clr = 1'b0; bus.load = 1'b0; bus.en = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    bus.en = 1'b0; bus.sync_clr = 1'b0; bus.load = 1'b0; bus.div_in = '0;
    step(2);
    chk_on = 1'b1;
    chk("rst_div_cur", 32'(bus.div_cur), 32'd200);
    chk("rst_clk_out", 32'(bus.clk_out), 32'd0);
    chk("rst_tap",     32'(bus.tap),     32'd0);
    rst = 1'b0;

    // Load 3 while disabled, then run: toggles on edges 4, 8, 12
    pulse_load(8'd3);
    chk("t1_div_cur", 32'(bus.div_cur), 32'd3);
    chk("t1_pending", 32'(bus.pending), 32'd0);
    bus.en = 1'b1;
    step(3);
    chk("t1_e3_clk", 32'(bus.clk_out), 32'd0);
    step(1);
    chk("t1_e4_clk",  32'(bus.clk_out), 32'd1);
    chk("t1_e4_tick", 32'(bus.tick),    32'd1);
    step(1);
    chk("t1_e5_tick", 32'(bus.tick),    32'd0);
    step(3);
    chk("t1_e8_clk",  32'(bus.clk_out), 32'd0);
    step(4);
    chk("t1_e12_clk", 32'(bus.clk_out), 32'd1);

    // div=7, load 1 at count 2: deferred to the count-7 terminal
    restart(8'd7);
    step(2);
    pulse_load(8'd1);
    chk("t2_pending", 32'(bus.pending), 32'd1);
    chk("t2_div_old", 32'(bus.div_cur), 32'd7);
    step(4);
    chk("t2_no_tick", 32'(bus.tick),    32'd0);
    step(1);
    chk("t2_tick",    32'(bus.tick),    32'd1);
    chk("t2_div_new", 32'(bus.div_cur), 32'd1);
    chk("t2_pend0",   32'(bus.pending), 32'd0);
    step(2);
    chk("t2_half2",   32'(bus.tick),    32'd1);

    // div=9, load 2 at count 6
    restart(8'd9);
    step(6);
    pulse_load(8'd2);
    chk("t3_div_old", 32'(bus.div_cur), 32'd9);
    step(3);
    chk("t3_tick",    32'(bus.tick),    32'd1);
    chk("t3_div_new", 32'(bus.div_cur), 32'd2);

    // Two loads before the terminal count: last one wins
    restart(8'd9);
    step(2);
    pulse_load(8'd3);
    pulse_load(8'd5);
    step(5);
    chk("t3b_no_tick", 32'(bus.tick),    32'd0);
    step(1);
    chk("t3b_div",     32'(bus.div_cur), 32'd5);

    // div=4, sync_clr at count 3 while clk_out=1
    restart(8'd4);
    step(5);
    chk("t4_high", 32'(bus.clk_out), 32'd1);
    step(3);
    bus.sync_clr = 1'b1;
    step(1);
    bus.sync_clr = 1'b0;
    chk("t4_clr_clk",  32'(bus.clk_out), 32'd0);
    chk("t4_clr_tick", 32'(bus.tick),    32'd0);
    step(4);
    chk("t4_e4_clk", 32'(bus.clk_out), 32'd0);
    step(1);
    chk("t4_e5_clk", 32'(bus.clk_out), 32'd1);

    // en low for 10 cycles at count 2, then div 0 loaded at the terminal
    restart(8'd7);
    step(2);
    bus.en = 1'b0;
    step(10);
    chk("t5_hold_tick", 32'(bus.tick),    32'd0);
    chk("t5_hold_clk",  32'(bus.clk_out), 32'd0);
    bus.en = 1'b1;
    step(1);
    chk("t5_cnt3_tap", 32'(bus.tap), 32'd0);
    step(1);
    chk("t5_cnt4_tap", 32'(bus.tap), 32'd1);
    step(3);
    pulse_load(8'd0);
    chk("t5_div0",  32'(bus.div_cur), 32'd0);
    chk("t5_clk_a", 32'(bus.clk_out), 32'd1);
    step(1);
    chk("t5_clk_b",  32'(bus.clk_out), 32'd0);
    chk("t5_tick_b", 32'(bus.tick),    32'd1);
    step(1);
    chk("t5_clk_c",  32'(bus.clk_out), 32'd1);
    chk("t5_tick_c", 32'(bus.tick),    32'd1);

    // Reset wins over load/sync_clr/en and discards a pending divisor
    restart(8'd9);
    step(2);
    pulse_load(8'd4);
    chk("t6_pending", 32'(bus.pending), 32'd1);
    rst = 1'b1; bus.load = 1'b1; bus.sync_clr = 1'b1; bus.div_in = 8'd5;
    step(1);
    chk("t6_div",     32'(bus.div_cur), 32'd200);
    chk("t6_pend",    32'(bus.pending), 32'd0);
    chk("t6_clk",     32'(bus.clk_out), 32'd0);
    chk("t6_tick",    32'(bus.tick),    32'd0);
    chk("t6_tap",     32'(bus.tap),     32'd0);
    rst = 1'b0; bus.load = 1'b0; bus.sync_clr = 1'b0; bus.en = 1'b0;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
